// File: rtl/wb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// wb_mem_arbiter
//   Two-master / one-slave Wishbone arbiter sitting downstream of the
//   load/store unit. The instruction fetch port (I, read-only) and the data
//   port (D) share one memory bus. Grants alternate round-robin when both
//   masters contend, and a watchdog forces an error on a slave that never
//   answers a strobe.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no owner, bus outputs quiet, arbitrating on cyc requests
//   GNT_I  | I owns the bus, bus signals and responses pass straight through
//   GNT_D  | D owns the bus, bus signals and responses pass straight through
//   TERM   | watchdog fired, bus dropped, waiting for the owner to drop cyc
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   i_addr_i/i_sel_i         I master address / byte select
//   i_cyc_i/i_stb_i          I master cycle / strobe (I never writes)
//   i_dat_o/i_ack_o/i_err_o  read data, ack and error back to I
//   d_addr_i/d_dat_i/d_sel_i D master address / write data / byte select
//   d_we_i/d_cyc_i/d_stb_i   D master write enable / cycle / strobe
//   d_dat_o/d_ack_o/d_err_o  read data, ack and error back to D
//   m_addr_o..m_stb_o        slave-side request signals
//   m_dat_i/m_ack_i/m_err_i  slave-side response signals
//   grant_o                  {D,I} one-hot owner, 00 when nobody owns the bus
// ---------------------------------------------------------------------------
module wb_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] i_addr_i,
  input  logic [3:0]  i_sel_i,
  input  logic        i_cyc_i,
  input  logic        i_stb_i,
  output logic [31:0] i_dat_o,
  output logic        i_ack_o,
  output logic        i_err_o,

  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_dat_i,
  input  logic [3:0]  d_sel_i,
  input  logic        d_we_i,
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_err_o,

  output logic [31:0] m_addr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,

  output logic [1:0]  grant_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TERM  = 2'd3
  } state_t;

  state_t        state;
  logic          last_d;    // previous owner was D
  logic          term_d;    // owner held in TERM is D
  logic [CW-1:0] cnt;

  logic live_i;
  logic live_d;
  logic own_cyc;
  logic term_cyc;
  logic slave_resp;
  logic timeout;

  // Reset gates everything combinationally so the bus drops in the same
  // cycle rst is seen, not one edge later.
  assign live_i = (state == GNT_I) && !rst;
  assign live_d = (state == GNT_D) && !rst;

  assign own_cyc  = (state == GNT_D) ? d_cyc_i : i_cyc_i;
  assign term_cyc = term_d ? d_cyc_i : i_cyc_i;

  assign slave_resp = m_ack_i | m_err_i;

  // A slave answer in the last watchdog cycle takes priority over the
  // forced error.
  assign timeout = (live_i || live_d) && m_stb_o && !slave_resp && (cnt == CNT_LAST);

  always_comb begin
    m_addr_o = '0;
    m_dat_o  = '0;
    m_sel_o  = '0;
    m_we_o   = 1'b0;
    m_cyc_o  = 1'b0;
    m_stb_o  = 1'b0;
    if (live_i) begin
      m_addr_o = i_addr_i;
      m_sel_o  = i_sel_i;
      m_cyc_o  = i_cyc_i;
      m_stb_o  = i_stb_i;
    end else if (live_d) begin
      m_addr_o = d_addr_i;
      m_dat_o  = d_dat_i;
      m_sel_o  = d_sel_i;
      m_we_o   = d_we_i;
      m_cyc_o  = d_cyc_i;
      m_stb_o  = d_stb_i;
    end
  end

  // Responses go only to the owner. Read data is broadcast; the masters
  // only sample it alongside their own ack.
  assign i_ack_o = live_i & m_ack_i;
  assign i_err_o = live_i & (m_err_i | timeout);
  assign d_ack_o = live_d & m_ack_i;
  assign d_err_o = live_d & (m_err_i | timeout);
  assign i_dat_o = m_dat_i;
  assign d_dat_o = m_dat_i;

  always_comb begin
    grant_o = 2'b00;
    if (!rst) begin
      unique case (state)
        GNT_I:   grant_o = 2'b01;
        GNT_D:   grant_o = 2'b10;
        TERM:    grant_o = term_d ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
      term_d <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          // On contention the master that did not go last wins; after
          // reset last_d=0 so D gets the first contended grant.
          if (d_cyc_i && (!i_cyc_i || !last_d)) begin
            state <= GNT_D;
          end else if (i_cyc_i) begin
            state <= GNT_I;
          end
        end
        GNT_I, GNT_D: begin
          if (timeout) begin
            state  <= TERM;
            term_d <= (state == GNT_D);
            cnt    <= '0;
          end else if (!own_cyc) begin
            state  <= IDLE;
            last_d <= (state == GNT_D);
            cnt    <= '0;
          end else if (slave_resp) begin
            cnt <= '0;
          end else if (m_stb_o) begin
            cnt <= cnt + 1'b1;
          end
        end
        TERM: begin
          cnt <= '0;
          if (!term_cyc) begin
            state  <= IDLE;
            last_d <= term_d;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;

  localparam int TO = 64;

  logic        clk;
  logic        rst;
  logic [31:0] i_addr_i;
  logic [3:0]  i_sel_i;
  logic        i_cyc_i;
  logic        i_stb_i;
  logic [31:0] i_dat_o;
  logic        i_ack_o;
  logic        i_err_o;
  logic [31:0] d_addr_i;
  logic [31:0] d_dat_i;
  logic [3:0]  d_sel_i;
  logic        d_we_i;
  logic        d_cyc_i;
  logic        d_stb_i;
  logic [31:0] d_dat_o;
  logic        d_ack_o;
  logic        d_err_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;
  logic        m_err_i;
  logic [1:0]  grant_o;

  wb_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_addr_i(i_addr_i), .i_sel_i(i_sel_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_addr_i(d_addr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i), .d_we_i(d_we_i),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .m_addr_o(m_addr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus (0 none, 1 I, 2 D), whether the
  // owner is stuck after a watchdog error, how many unanswered strobe
  // cycles it has accumulated, and who went last.
  int owner  = 0;
  bit stuck  = 1'b0;
  int waited = 0;
  bit last_d = 1'b0;
  bit exp_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Settle combinational paths, then compare every output with the model.
  task automatic eval();
    bit gi, gd, cyc_x, stb_x;
    logic [31:0] e_addr, e_dat;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [1:0]  e_gnt;
    #2;
    gi = !rst && owner == 1 && !stuck;
    gd = !rst && owner == 2 && !stuck;
    e_addr = gi ? i_addr_i : gd ? d_addr_i : 32'h0;
    e_dat  = gd ? d_dat_i : 32'h0;
    e_sel  = gi ? i_sel_i : gd ? d_sel_i : 4'h0;
    e_we   = gd ? d_we_i : 1'b0;
    cyc_x  = gi ? i_cyc_i : gd ? d_cyc_i : 1'b0;
    stb_x  = gi ? i_stb_i : gd ? d_stb_i : 1'b0;
    exp_to = (gi || gd) && stb_x && !m_ack_i && !m_err_i && waited == TO - 1;
    e_gnt  = rst ? 2'b00 : owner == 1 ? 2'b01 : owner == 2 ? 2'b10 : 2'b00;
    check("grant",  32'(grant_o), 32'(e_gnt));
    check("m_addr", m_addr_o, e_addr);
    check("m_dat",  m_dat_o, e_dat);
    check("m_ctl",  32'({m_sel_o, m_we_o, m_cyc_o, m_stb_o}), 32'({e_sel, e_we, cyc_x, stb_x}));
    check("i_resp", 32'({i_ack_o, i_err_o}), 32'({gi & m_ack_i, gi & (m_err_i | exp_to)}));
    check("d_resp", 32'({d_ack_o, d_err_o}), 32'({gd & m_ack_i, gd & (m_err_i | exp_to)}));
    check("i_dat",  i_dat_o, m_dat_i);
    check("d_dat",  d_dat_o, m_dat_i);
  endtask

  // Clock edge; the model advances on the same (still stable) inputs.
  task automatic tick();
    bit xcyc, xstb;
    @(posedge clk);
    xcyc = owner == 2 ? d_cyc_i : i_cyc_i;
    xstb = owner == 2 ? d_stb_i : i_stb_i;
    if (rst) begin
      owner = 0; stuck = 0; waited = 0; last_d = 0;
    end else if (owner == 0) begin
      waited = 0;
      if (d_cyc_i && (!i_cyc_i || !last_d)) owner = 2;
      else if (i_cyc_i) owner = 1;
    end else if (stuck) begin
      if (!xcyc) begin last_d = (owner == 2); owner = 0; stuck = 0; end
    end else if (exp_to) begin
      stuck = 1; waited = 0;
    end else if (!xcyc) begin
      last_d = (owner == 2); owner = 0; waited = 0;
    end else if (m_ack_i || m_err_i) begin
      waited = 0;
    end else if (xstb) begin
      waited++;
    end
    #1;
  endtask

  task automatic step();
    eval();
    tick();
  endtask

  initial begin
    rst = 1; i_addr_i = 0; i_sel_i = 0; i_cyc_i = 0; i_stb_i = 0;
    d_addr_i = 0; d_dat_i = 0; d_sel_i = 0; d_we_i = 0; d_cyc_i = 0; d_stb_i = 0;
    m_dat_i = 0; m_ack_i = 0; m_err_i = 0;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    eval();
    check("reset_grant", 32'(grant_o), 32'h0);
    check("reset_cyc", 32'(m_cyc_o), 32'h0);
    tick();

    // 1: I-only fetch, slave acks two cycles after the first strobe.
    i_addr_i = $urandom; i_sel_i = 4'hF; i_cyc_i = 1; i_stb_i = 1;
    step();
    eval(); check("t1_grant", 32'(grant_o), 32'h1); tick();
    step();
    m_ack_i = 1; m_dat_i = $urandom;
    eval();
    check("t1_ack", 32'({i_ack_o, d_ack_o}), 32'b10);
    check("t1_dat", i_dat_o, m_dat_i);
    tick();
    m_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
    step();
    eval(); check("t1_idle", 32'(grant_o), 32'h0); tick();

    // 2: D write.
    d_we_i = 1; d_sel_i = 4'h3; d_dat_i = 32'hCAFE_F00D; d_addr_i = 32'h100;
    d_cyc_i = 1; d_stb_i = 1;
    step();
    eval();
    check("t2_bus", 32'({m_we_o, m_sel_o}), 32'h13);
    check("t2_wdat", m_dat_o, 32'hCAFE_F00D);
    check("t2_addr", m_addr_o, 32'h100);
    tick();
    m_ack_i = 1;
    eval(); check("t2_ack", 32'(d_ack_o), 32'h1); tick();
    m_ack_i = 0; d_cyc_i = 0; d_stb_i = 0; d_we_i = 0;
    step();

    // 3: contention after reset: D first, then I on the next contention.
    rst = 1; step(); rst = 0;
    i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1;
    step();
    eval(); check("t3_first", 32'(grant_o), 32'h2); tick();
    d_cyc_i = 0; d_stb_i = 0;
    step();
    d_cyc_i = 1; d_stb_i = 1;
    eval(); check("t3_gap", 32'(grant_o), 32'h0); tick();
    eval(); check("t3_second", 32'(grant_o), 32'h1); tick();
    i_cyc_i = 0; i_stb_i = 0; d_cyc_i = 0; d_stb_i = 0;
    step(); step();

    // 4: D strobe held, slave silent: error on exactly the 64th strobe cycle.
    d_cyc_i = 1; d_stb_i = 1; d_addr_i = $urandom;
    step();
    for (int k = 0; k < TO; k++) begin
      eval(); check("t4_err", 32'(d_err_o), 32'(k == TO - 1)); tick();
    end
    eval(); check("t4_term_cyc", 32'(m_cyc_o), 32'h0); tick();
    d_cyc_i = 0; d_stb_i = 0;
    step();
    eval(); check("t4_idle", 32'(grant_o), 32'h0); tick();

    // 5: ack in the 64th cycle beats the watchdog; unsolicited ack in IDLE.
    d_cyc_i = 1; d_stb_i = 1;
    step();
    for (int k = 0; k < TO - 1; k++) step();
    m_ack_i = 1;
    eval(); check("t5_resp", 32'({d_ack_o, d_err_o}), 32'b10); tick();
    m_ack_i = 0; d_cyc_i = 0; d_stb_i = 0;
    step();
    m_ack_i = 1;
    eval(); check("t5_unsol", 32'({i_ack_o, d_ack_o}), 32'b00); tick();
    m_ack_i = 0;

    // 6: reset in the middle of a D cycle, then a normal I fetch.
    d_cyc_i = 1; d_stb_i = 1;
    step(); step();
    rst = 1;
    eval(); check("t6_rst_cyc", 32'({m_cyc_o, grant_o}), 32'h0); tick();
    rst = 0; d_cyc_i = 0; d_stb_i = 0;
    eval(); check("t6_after", 32'({m_cyc_o, grant_o}), 32'h0); tick();
    i_cyc_i = 1; i_stb_i = 1;
    step();
    m_ack_i = 1; m_dat_i = $urandom;
    eval(); check("t6_fetch", 32'({grant_o, i_ack_o}), 32'b011); tick();
    m_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
    step();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) i_cyc_i = ~i_cyc_i;
      if ($urandom_range(0, 5) == 0) d_cyc_i = ~d_cyc_i;
      i_stb_i = i_cyc_i & ($urandom_range(0, 3) != 0);
      d_stb_i = d_cyc_i & ($urandom_range(0, 3) != 0);
      i_addr_i = $urandom; i_sel_i = 4'($urandom);
      d_addr_i = $urandom; d_dat_i = $urandom; d_sel_i = 4'($urandom);
      d_we_i = 1'($urandom);
      m_dat_i = $urandom;
      m_ack_i = ($urandom_range(0, 3) == 0);
      m_err_i = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
